// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed address/data RTC bus engine.
// Holds the FSM state encoding, the pin bundle and the RTC register map.
package rtc_bus_pkg;

   localparam int RTC_PHASE_CYC = 4;

   // RTC register map (time/date block is contiguous, commands at the top)
   localparam logic [7:0] RTC_ADDR_SEG       = 8'h21;
   localparam logic [7:0] RTC_ADDR_MIN       = 8'h22;
   localparam logic [7:0] RTC_ADDR_HORA      = 8'h23;
   localparam logic [7:0] RTC_ADDR_DIA       = 8'h24;
   localparam logic [7:0] RTC_ADDR_MES       = 8'h25;
   localparam logic [7:0] RTC_ADDR_JAHR      = 8'h26;
   localparam logic [7:0] RTC_ADDR_TIMER     = 8'h41;
   localparam logic [7:0] RTC_CMD_TRANSFER   = 8'hF0;
   localparam logic [7:0] RTC_CMD_UPDATE     = 8'hF1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      GAP1 = 3'd2,
      DATA = 3'd3,
      GAP2 = 3'd4,
      FIN  = 3'd5
   } rtc_state_e;

   typedef struct packed {
      logic a_d;
      logic cs;
      logic rd;
      logic wr;
      logic oe;
   } rtc_pins_t;

   localparam rtc_pins_t RTC_PINS_IDLE = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0};

   // Pin levels for a given state; the address phase also pulses wr low.
   function automatic rtc_pins_t rtc_pins(input rtc_state_e st, input logic wr_burst);
      rtc_pins_t p;
      p = RTC_PINS_IDLE;
      case (st)
         ADDR: begin
            p.a_d = 1'b0;
            p.cs  = 1'b0;
            p.wr  = 1'b0;
            p.oe  = 1'b1;
         end
         DATA: begin
            p.cs = 1'b0;
            if (wr_burst) begin
               p.wr = 1'b0;
               p.oe = 1'b1;
            end else begin
               p.rd = 1'b0;
            end
         end
         default: p = RTC_PINS_IDLE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-phase down-counter: reload on phase entry, flags the final cycle of the phase.
module rtc_phase_timer #(
   parameter int PHASE_CYC = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic last_cyc
);

   localparam int CW = $clog2(PHASE_CYC);
   localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= RELOAD;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign last_cyc = en && (cnt_reg == '0);

endmodule

// File: rtl/rtc_burst_bus_ctrl.sv
// Burst bus-cycle engine for the multiplexed RTC bus: runs 0..NREG register
// reads or writes from one start pulse, with all bus pins registered.
module rtc_burst_bus_ctrl
   import rtc_bus_pkg::*;
#(
   parameter int DW        = 8,
   parameter int NREG      = 10,
   parameter int PHASE_CYC = RTC_PHASE_CYC
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       rw,
   input  logic                       addr_inc,
   input  logic [DW-1:0]              base_addr,
   input  logic [$clog2(NREG+1)-1:0]  len,
   input  logic [NREG*DW-1:0]         wr_bus,
   input  logic [DW-1:0]              bus_in,
   output logic [DW-1:0]              bus_out,
   output logic                       bus_oe,
   output logic                       a_d,
   output logic                       cs,
   output logic                       rd,
   output logic                       wr,
   output logic [NREG*DW-1:0]         rd_bus,
   output logic                       busy,
   output logic                       done
);

   localparam int LW = $clog2(NREG + 1);

   rtc_state_e        state_reg, state_next;
   logic              rw_reg, inc_reg;
   logic [DW-1:0]     base_reg;
   logic [LW-1:0]     len_reg, beat_reg, beat_next, eff_len;
   logic [NREG*DW-1:0] wdata_reg;
   logic              accept, last_cyc, in_beat, next_in_beat, timer_load;

   rtc_pins_t         pins_reg, pins_next;
   logic [DW-1:0]     bus_out_reg, bus_out_next, addr_next;
   logic              busy_reg, busy_next, done_reg, done_next;

   assign accept       = (state_reg == IDLE) && start;
   assign eff_len      = (len > LW'(NREG)) ? LW'(NREG) : len;
   assign in_beat      = state_reg inside {ADDR, GAP1, DATA, GAP2};
   assign next_in_beat = state_next inside {ADDR, GAP1, DATA, GAP2};
   assign timer_load   = (state_next != state_reg) && next_in_beat;

   rtc_phase_timer #(
      .PHASE_CYC (PHASE_CYC)
   ) u_phase_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .en       (in_beat),
      .last_cyc (last_cyc)
   );

   // State register plus the operands latched with an accepted start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         beat_reg  <= '0;
         rw_reg    <= 1'b0;
         inc_reg   <= 1'b0;
         base_reg  <= '0;
         len_reg   <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         if (accept) begin
            rw_reg    <= rw;
            inc_reg   <= addr_inc;
            base_reg  <= base_addr;
            len_reg   <= eff_len;
            wdata_reg <= wr_bus;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      case (state_reg)
         IDLE: begin
            beat_next = '0;
            if (start) state_next = (eff_len == '0) ? FIN : ADDR;
         end
         ADDR: if (last_cyc) state_next = GAP1;
         GAP1: if (last_cyc) state_next = DATA;
         DATA: if (last_cyc) state_next = GAP2;
         GAP2: begin
            if (last_cyc) begin
               if (beat_reg == len_reg - 1'b1) begin
                  state_next = FIN;
               end else begin
                  state_next = ADDR;
                  beat_next  = beat_reg + 1'b1;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
            beat_next  = '0;
         end
         default: begin
            state_next = IDLE;
            beat_next  = '0;
         end
      endcase
   end

   // Pins are computed from the upcoming state so the registered outputs line up with it
   always_comb begin
      addr_next    = (state_reg == IDLE) ? base_addr
                   : base_reg + (inc_reg ? DW'(beat_next) : DW'(0));
      pins_next    = rtc_pins(state_next, rw_reg);
      bus_out_next = '0;
      if (state_next == ADDR) begin
         bus_out_next = addr_next;
      end else if ((state_next == DATA) && rw_reg) begin
         bus_out_next = wdata_reg[beat_next*DW +: DW];
      end
      busy_next = next_in_beat;
      done_next = (state_next == FIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pins_reg    <= RTC_PINS_IDLE;
         bus_out_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         pins_reg    <= pins_next;
         bus_out_reg <= bus_out_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   // Read capture on the final DATA cycle; beats outside the burst hold their value
   for (genvar gi = 0; gi < NREG; gi++) begin : g_rd_beat
      logic [DW-1:0] rd_word_reg;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_word_reg <= '0;
         end else if ((state_reg == DATA) && last_cyc && !rw_reg && (beat_reg == LW'(gi))) begin
            rd_word_reg <= bus_in;
         end
      end
      assign rd_bus[gi*DW +: DW] = rd_word_reg;
   end

   assign a_d     = pins_reg.a_d;
   assign cs      = pins_reg.cs;
   assign rd      = pins_reg.rd;
   assign wr      = pins_reg.wr;
   assign bus_oe  = pins_reg.oe;
   assign bus_out = bus_out_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

   no_pad_contention: assert property (@(posedge clk) disable iff (!reset) !(pins_reg.oe && !pins_reg.rd));

endmodule

// File: tb/tb_rtc_burst_bus_ctrl.sv
// Directed bench for rtc_burst_bus_ctrl with a small RTC responder returning 0xA0+addr.
module tb_rtc_burst_bus_ctrl;
   import rtc_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, rw, addr_inc;
   logic [7:0]  base_addr;
   logic [3:0]  len;
   logic [79:0] wr_bus;
   logic [7:0]  bus_in;
   logic [7:0]  bus_out;
   logic        bus_oe, a_d, cs, rd, wr;
   logic [79:0] rd_bus;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   rtc_burst_bus_ctrl #(.DW(8), .NREG(10), .PHASE_CYC(4)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr_inc(addr_inc),
      .base_addr(base_addr), .len(len), .wr_bus(wr_bus), .bus_in(bus_in),
      .bus_out(bus_out), .bus_oe(bus_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
      .rd_bus(rd_bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // RTC responder: latches the address phase, answers reads with 0xA0+addr
   logic [7:0] rtc_addr = 8'h00;
   always @(posedge clk) if (!cs && !a_d) rtc_addr <= bus_out;
   assign bus_in = (!rd) ? rtc_addr + 8'hA0 : 8'h00;

   // Bus monitor: logs address phases and write data phases
   logic [7:0] addr_log [0:255];
   logic [7:0] data_log [0:255];
   int n_addr = 0, n_data = 0, n_cont = 0, n_addr_bad = 0, n_cs_act = 0;
   logic prev_a_d = 1'b1, prev_cs = 1'b1;
   always @(negedge clk) begin
      if (!a_d && prev_a_d) begin
         addr_log[n_addr & 255] <= bus_out;
         n_addr <= n_addr + 1;
      end
      if (a_d && !cs && !wr && prev_cs) begin
         data_log[n_data & 255] <= bus_out;
         n_data <= n_data + 1;
      end
      if (bus_oe && !rd) n_cont <= n_cont + 1;
      if (!a_d && (wr || cs || !bus_oe)) n_addr_bad <= n_addr_bad + 1;
      if (!cs) n_cs_act <= n_cs_act + 1;
      prev_a_d <= a_d;
      prev_cs  <= cs;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic rw_i, input logic inc_i, input logic [7:0] base_i,
                      input logic [3:0] len_i, input logic [79:0] wbus_i, input int exp_done,
                      input int inj_a, input int inj_b, input string tag);
      int cyc;
      bit got;
      @(posedge clk); #1;
      start = 1'b1; rw = rw_i; addr_inc = inc_i; base_addr = base_i; len = len_i; wr_bus = wbus_i;
      cyc = 0;
      got = 0;
      while (!got && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == inj_a) || (cyc == inj_b);
         rw = ~rw_i; addr_inc = ~inc_i; base_addr = 8'h99; len = 4'd4; wr_bus = {10{8'hEE}};
         @(negedge clk);
         if (cyc == 1) chk({tag, "_busy1"}, 128'(busy), 128'(exp_done > 1));
         if (done === 1'b1) got = 1;
      end
      chk({tag, "_done_cyc"}, 128'(cyc), 128'(exp_done));
      chk({tag, "_busy_at_done"}, 128'(busy), 128'(0));
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_after"}, 128'({busy, done, cs}), 128'(3'b001));
      $display("burst %s: rw=%0d inc=%0d base=%02h len=%0d done after %0d cycles",
               tag, rw_i, inc_i, base_i, len_i, cyc);
   endtask

   int na, nd, nc;

   initial begin
      reset = 1'b0; start = 1'b0; rw = 1'b0; addr_inc = 1'b0;
      base_addr = 8'h00; len = 4'd0; wr_bus = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pins", 128'({a_d, cs, rd, wr, bus_oe, busy, done}), 128'(7'b1111000));
      chk("rst_bus_out", 128'(bus_out), 128'(0));
      chk("rst_rd_bus", 128'(rd_bus), 128'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_pins", 128'({a_d, cs, rd, wr, bus_oe, busy, done}), 128'(7'b1111000));

      // 1: sequential write burst
      na = n_addr; nd = n_data;
      run(1'b1, 1'b1, RTC_ADDR_SEG, 4'd3, {56'h0, 24'h563412}, 49, -1, -1, "t1_write");
      chk("t1_addr_cnt", 128'(n_addr - na), 128'(3));
      chk("t1_addrs", 128'({addr_log[na & 255], addr_log[(na + 1) & 255], addr_log[(na + 2) & 255]}), 128'(24'h212223));
      chk("t1_data", 128'({data_log[nd & 255], data_log[(nd + 1) & 255], data_log[(nd + 2) & 255]}), 128'(24'h123456));
      chk("t1_rd_bus_untouched", 128'(rd_bus), 128'(0));

      // 2: reads, second burst leaves beats 3/4 from the first
      run(1'b0, 1'b1, 8'h30, 4'd5, '0, 81, -1, -1, "t2_read5");
      chk("t2_rd_bus_a", 128'(rd_bus), 128'(80'h0000_0000_00D4_D3D2_D1D0));
      run(1'b0, 1'b1, 8'h21, 4'd3, '0, 49, -1, -1, "t2_read3");
      chk("t2_rd_bus_b", 128'(rd_bus), 128'(80'h0000_0000_00D4_D3C3_C2C1));

      // 3: repeated command address, then address wrap
      na = n_addr;
      run(1'b1, 1'b0, RTC_CMD_UPDATE, 4'd2, {64'h0, 16'h0201}, 33, -1, -1, "t3_repeat");
      chk("t3_repeat_addrs", 128'({addr_log[na & 255], addr_log[(na + 1) & 255]}), 128'(16'hF1F1));
      na = n_addr;
      run(1'b1, 1'b1, 8'hFF, 4'd2, {64'h0, 16'h0403}, 33, -1, -1, "t3_wrap");
      chk("t3_wrap_addrs", 128'({addr_log[na & 255], addr_log[(na + 1) & 255]}), 128'(16'hFF00));

      // 4: zero-length and over-length bursts
      na = n_addr; nc = n_cs_act;
      run(1'b1, 1'b1, 8'h21, 4'd0, '0, 1, -1, -1, "t4_len0");
      chk("t4_len0_no_addr", 128'(n_addr - na), 128'(0));
      chk("t4_len0_cs_idle", 128'(n_cs_act - nc), 128'(0));
      na = n_addr;
      run(1'b1, 1'b1, 8'h21, 4'd15, {10{8'h5A}}, 161, -1, -1, "t4_len15");
      chk("t4_len15_beats", 128'(n_addr - na), 128'(10));
      chk("t4_len15_last_addr", 128'(addr_log[(na + 9) & 255]), 128'(8'h2A));

      // 5: starts mid-burst and in the done cycle are ignored
      na = n_addr; nd = n_data;
      run(1'b1, 1'b1, 8'h40, 4'd2, {64'h0, 16'hBBAA}, 33, 5, 33, "t5_ignore");
      chk("t5_addrs", 128'({addr_log[na & 255], addr_log[(na + 1) & 255]}), 128'(16'h4041));
      chk("t5_data", 128'({data_log[nd & 255], data_log[(nd + 1) & 255]}), 128'(16'hAABB));
      chk("t5_beats", 128'(n_addr - na), 128'(2));
      run(1'b0, 1'b1, 8'h50, 4'd1, '0, 17, -1, -1, "t5_after");
      chk("t5_rd_bus", 128'(rd_bus), 128'(80'h0000_0000_00D4_D3C3_C2F0));

      // 6: async reset during DATA of beat 1
      @(posedge clk); #1;
      start = 1'b1; rw = 1'b0; addr_inc = 1'b1; base_addr = 8'h21; len = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("t6_in_data_read", 128'({a_d, cs, rd, busy}), 128'(4'b1001));
      #1 reset = 1'b0;
      #1;
      chk("t6_rst_pins", 128'({a_d, cs, rd, wr, bus_oe, busy, done}), 128'(7'b1111000));
      chk("t6_rst_rd_bus", 128'(rd_bus), 128'(0));
      chk("t6_rst_bus_out", 128'(bus_out), 128'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      run(1'b0, 1'b1, 8'h10, 4'd2, '0, 33, -1, -1, "t6_fresh");
      chk("t6_fresh_rd_bus", 128'(rd_bus), 128'(80'h0000_0000_0000_0000_B1B0));

      chk("no_contention", 128'(n_cont), 128'(0));
      chk("addr_phase_pins", 128'(n_addr_bad), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
